unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage RV64 pipeline.
- Sequences one outstanding transaction at a time over a variable-latency req/ack memory port.
- Returns fetch and load/store results to the two stages.
- Produces if_stall and dm_stall, which the hazard logic ORs into PC/IF_ID write-enable and MEM-stage hold.
- Discards an in-flight fetch when a taken branch flushes the front end.

---
 rtl/unified_mem_arbiter_if.sv | 44 ++++
 rtl/unified_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Handshake bundle between the IF/MEM stages, the arbiter and the
// single-ported unified memory.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              flush;
  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, flush,
    input  dm_read, dm_write, dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_valid, if_stall,
    output dm_rdata, dm_valid, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, flush,
    output dm_read, dm_write, dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_stall,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one req/ack memory
// port, one transaction at a time, with anti-starvation for fetch.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  unified_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              kill_q, kill_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;

  logic dm_pend;
  logic if_ok;
  logic force_if;

  assign dm_pend  = bus.dm_read | bus.dm_write;
  assign if_ok    = bus.if_req & ~bus.flush;
  assign force_if = if_ok & (starve_cnt_q == SMAX);

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;
    kill_d       = kill_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (dm_pend && !force_if) begin
          state_d     = DM_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_write;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          if (if_ok && starve_cnt_q != SMAX)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (if_ok) begin
          state_d      = IF_WAIT;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          starve_cnt_d = 4'd0;
        end
      end
      IF_WAIT: begin
        if (bus.flush)
          kill_d = 1'b1;
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          kill_d    = 1'b0;
          // a flush landing on the ack cycle kills the fetch too
          if (!kill_q && !bus.flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end
      end
      DM_WAIT: begin
        if (bus.mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          dm_valid_d = 1'b1;
          dm_rdata_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      kill_q       <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
      kill_q       <= kill_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.dm_stall  = dm_pend & ~dm_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: fetch, load, store,
// starvation, flush and mid-transaction reset.
module tb_unified_mem_arbiter;

  localparam int LAT = 2;

  logic clk;
  logic rst_n;

  unified_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk;
  int n_pass;
  int if_vcnt;
  int both_cnt;
  int rcnt;
  logic prev_req;
  logic [63:0] grant_q[$];
  logic [3:0]  starve_q[$];

  function automatic logic [63:0] mdl(input logic [63:0] a);
    if (a == 64'h100) return 64'hDEAD;
    return a ^ 64'hFFFF_0000_0000_0000;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory: ack LAT cycles after mem_req is first seen
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rcnt = 0;
        bus.mem_ack = 1'b0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        rcnt = 0;
      end else if (bus.mem_req) begin
        rcnt++;
        if (rcnt == LAT + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mdl(bus.mem_addr);
        end
      end
    end
  end

  initial begin
    prev_req = 1'b0;
    if_vcnt  = 0;
    both_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_req && !prev_req) begin
        grant_q.push_back(bus.mem_addr);
        starve_q.push_back(dut.starve_cnt_q);
      end
      prev_req = rst_n ? bus.mem_req : 1'b0;
      if (bus.if_valid) if_vcnt++;
      if (bus.if_valid && bus.dm_valid) both_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0)
      $display("FAIL rst_req_we got %b%b exp 00", bus.mem_req, bus.mem_we);
    else n_pass++;
    n_chk++;
    if (bus.mem_addr !== 64'h0 || bus.mem_wdata !== 64'h0)
      $display("FAIL rst_addr_wdata got %h %h exp 0 0", bus.mem_addr, bus.mem_wdata);
    else n_pass++;
    n_chk++;
    if (bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0)
      $display("FAIL rst_valid got %b%b exp 00", bus.if_valid, bus.dm_valid);
    else n_pass++;
    n_chk++;
    if (bus.if_rdata !== 64'h0 || bus.dm_rdata !== 64'h0)
      $display("FAIL rst_rdata got %h %h exp 0 0", bus.if_rdata, bus.dm_rdata);
    else n_pass++;
    n_chk++;
    if (dut.starve_cnt_q !== 4'd0)
      $display("FAIL rst_starve got %0d exp 0", dut.starve_cnt_q);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_chk++;
    if (bus.mem_req !== 1'b0)
      $display("FAIL rst_idle_req got %b exp 0", bus.mem_req);
    else n_pass++;
  endtask

  task automatic test_single_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h100;
    step();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 64'h100)
      $display("FAIL sf_req got req=%b we=%b addr=%h exp 1 0 100",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    else n_pass++;
    n_chk++;
    if (bus.if_stall !== 1'b1 || bus.if_valid !== 1'b0)
      $display("FAIL sf_stall1 got stall=%b valid=%b exp 1 0", bus.if_stall, bus.if_valid);
    else n_pass++;
    step();
    step();
    n_chk++;
    if (bus.if_stall !== 1'b1 || bus.if_valid !== 1'b0 || bus.mem_req !== 1'b1)
      $display("FAIL sf_stall3 got stall=%b valid=%b req=%b exp 1 0 1",
               bus.if_stall, bus.if_valid, bus.mem_req);
    else n_pass++;
    step();
    n_chk++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 64'hDEAD)
      $display("FAIL sf_valid got valid=%b data=%h exp 1 dead", bus.if_valid, bus.if_rdata);
    else n_pass++;
    n_chk++;
    if (bus.if_stall !== 1'b0 || bus.mem_req !== 1'b0)
      $display("FAIL sf_done got stall=%b req=%b exp 0 0", bus.if_stall, bus.mem_req);
    else n_pass++;
    bus.if_req = 1'b0;
    step();
    n_chk++;
    if (bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0)
      $display("FAIL sf_pulse got valid=%b req=%b exp 0 0", bus.if_valid, bus.mem_req);
    else n_pass++;
  endtask

  task automatic test_load_fetch();
    logic stall_ok;
    stall_ok = 1'b1;
    grant_q.delete();
    bus.dm_read = 1'b1;
    bus.dm_addr = 64'h2000;
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h104;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.dm_valid) break;
      if (!bus.if_stall || bus.if_valid) stall_ok = 1'b0;
    end
    n_chk++;
    if (bus.dm_valid !== 1'b1 || bus.if_valid !== 1'b0)
      $display("FAIL lf_dm_first got dm_valid=%b if_valid=%b exp 1 0",
               bus.dm_valid, bus.if_valid);
    else n_pass++;
    n_chk++;
    if (bus.dm_rdata !== mdl(64'h2000))
      $display("FAIL lf_dm_data got %h exp %h", bus.dm_rdata, mdl(64'h2000));
    else n_pass++;
    bus.dm_read = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.if_valid) break;
      if (!bus.if_stall) stall_ok = 1'b0;
    end
    n_chk++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== mdl(64'h104))
      $display("FAIL lf_if got valid=%b data=%h exp 1 %h",
               bus.if_valid, bus.if_rdata, mdl(64'h104));
    else n_pass++;
    n_chk++;
    if (stall_ok !== 1'b1)
      $display("FAIL lf_if_stall got %b exp 1", stall_ok);
    else n_pass++;
    n_chk++;
    if (grant_q.size() !== 2 || grant_q[0] !== 64'h2000 || grant_q[1] !== 64'h104)
      $display("FAIL lf_order got n=%0d first=%h exp 2 2000", grant_q.size(), grant_q[0]);
    else n_pass++;
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic test_store();
    logic hold_ok;
    logic req_seen;
    logic iv_seen;
    hold_ok  = 1'b1;
    req_seen = 1'b0;
    iv_seen  = 1'b0;
    bus.dm_write = 1'b1;
    bus.dm_addr  = 64'h3008;
    bus.dm_wdata = 64'h55;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.if_valid) iv_seen = 1'b1;
      if (bus.dm_valid) break;
      if (bus.mem_req) begin
        req_seen = 1'b1;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 64'h55 || bus.mem_addr !== 64'h3008)
          hold_ok = 1'b0;
      end
    end
    n_chk++;
    if (bus.dm_valid !== 1'b1)
      $display("FAIL st_valid got %b exp 1", bus.dm_valid);
    else n_pass++;
    n_chk++;
    if (req_seen !== 1'b1 || hold_ok !== 1'b1)
      $display("FAIL st_hold got seen=%b hold=%b exp 1 1", req_seen, hold_ok);
    else n_pass++;
    n_chk++;
    if (iv_seen !== 1'b0)
      $display("FAIL st_no_if got %b exp 0", iv_seen);
    else n_pass++;
    bus.dm_write = 1'b0;
    step();
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.dm_valid !== 1'b0)
      $display("FAIL st_end got req=%b valid=%b exp 0 0", bus.mem_req, bus.dm_valid);
    else n_pass++;
  endtask

  task automatic test_starvation();
    logic [63:0] exp_a [6];
    logic [3:0]  exp_c [6];
    exp_a = '{64'h4000, 64'h4000, 64'h4000, 64'h4000, 64'h200, 64'h4000};
    exp_c = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    grant_q.delete();
    starve_q.delete();
    bus.dm_read = 1'b1;
    bus.dm_addr = 64'h4000;
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h200;
    for (int i = 0; i < 80; i++) begin
      step();
      if (grant_q.size() >= 6) break;
    end
    bus.dm_read = 1'b0;
    bus.if_req  = 1'b0;
    n_chk++;
    if (grant_q.size() < 6)
      $display("FAIL sv_count got %0d exp 6", grant_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < 6; k++) begin
        n_chk++;
        if (grant_q[k] !== exp_a[k] || starve_q[k] !== exp_c[k])
          $display("FAIL sv_grant%0d got addr=%h cnt=%0d exp %h %0d",
                   k, grant_q[k], starve_q[k], exp_a[k], exp_c[k]);
        else n_pass++;
      end
    end
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_flush();
    int base;
    grant_q.delete();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h300;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.mem_req) break;
    end
    n_chk++;
    if (bus.mem_req !== 1'b1)
      $display("FAIL fl_req got %b exp 1", bus.mem_req);
    else n_pass++;
    base = if_vcnt;
    bus.flush = 1'b1;
    step();
    bus.flush   = 1'b0;
    bus.if_addr = 64'h400;
    for (int i = 0; i < 20; i++) begin
      step();
      if (grant_q.size() >= 2) break;
    end
    n_chk++;
    if (grant_q.size() !== 2 || grant_q[1] !== 64'h400)
      $display("FAIL fl_regrant got n=%0d addr=%h exp 2 400", grant_q.size(), grant_q[1]);
    else n_pass++;
    n_chk++;
    if (if_vcnt !== base)
      $display("FAIL fl_no_valid got %0d exp %0d", if_vcnt, base);
    else n_pass++;
    n_chk++;
    if (bus.if_rdata !== mdl(64'h200))
      $display("FAIL fl_rdata_kept got %h exp %h", bus.if_rdata, mdl(64'h200));
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.if_valid) break;
    end
    n_chk++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== mdl(64'h400))
      $display("FAIL fl_new got valid=%b data=%h exp 1 %h",
               bus.if_valid, bus.if_rdata, mdl(64'h400));
    else n_pass++;
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.dm_read = 1'b1;
    bus.dm_addr = 64'h5000;
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h600;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.mem_req) break;
    end
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h5000 || dut.starve_cnt_q !== 4'd1)
      $display("FAIL rm_pre got req=%b addr=%h cnt=%0d exp 1 5000 1",
               bus.mem_req, bus.mem_addr, dut.starve_cnt_q);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.dm_valid !== 1'b0 || dut.starve_cnt_q !== 4'd0)
      $display("FAIL rm_async got req=%b valid=%b cnt=%0d exp 0 0 0",
               bus.mem_req, bus.dm_valid, dut.starve_cnt_q);
    else n_pass++;
    bus.dm_read = 1'b0;
    step();
    step();
    grant_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant_q.size() >= 1) break;
    end
    n_chk++;
    if (grant_q.size() !== 1 || grant_q[0] !== 64'h600 || bus.mem_we !== 1'b0)
      $display("FAIL rm_grant got n=%0d addr=%h we=%b exp 1 600 0",
               grant_q.size(), grant_q[0], bus.mem_we);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.if_valid) break;
    end
    n_chk++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== mdl(64'h600))
      $display("FAIL rm_fetch got valid=%b data=%h exp 1 %h",
               bus.if_valid, bus.if_rdata, mdl(64'h600));
    else n_pass++;
    bus.if_req = 1'b0;
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.flush    = 1'b0;
    bus.dm_read  = 1'b0;
    bus.dm_write = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    test_reset();
    test_single_fetch();
    test_load_fetch();
    test_store();
    test_starvation();
    test_flush();
    test_reset_mid();
    n_chk++;
    if (both_cnt !== 0)
      $display("FAIL valid_overlap got %0d exp 0", both_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
